midi_activity_stretch: RTL

Converts single-cycle per-port MIDI traffic strobes into human-visible LED activity bits. It takes one byte-received strobe per input port and one byte-sent strobe per output port from the UART stages. It drives the 16-bit `in` / `out` activity buses of the LED matrix scanner. Each channel holds its LED on for a fixed window, then forces a dark gap, so sustained traffic shows as a blink rather than a solid light.

---
 rtl/midi_pkg.sv | 32 +++
 rtl/activity_chan.sv | 99 +++++++++
 rtl/midi_activity_stretch.sv | 69 ++++++
 3 files changed

// File: rtl/midi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : midi_pkg                                                 |
// | Description : Shared types and defaults for the MIDI activity LEDs,    |
// |               the router and the LED matrix scanner.                   |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package midi_pkg;

  // Ports per direction, shared with the router and LED scanner.
  localparam int NCH          = 16;

  // Defaults: 1 ms tick at 12 MHz, 40 ms lit, 20 ms forced dark.
  localparam int DEF_TICK_DIV = 12000;
  localparam int DEF_HOLD     = 40;
  localparam int DEF_GAP      = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ON   = 2'b01,
    ST_GAP  = 2'b10
  } chan_state_t;

  // Counter width able to hold the larger of the two window lengths.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/activity_chan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : activity_chan                                            |
// | Description : One LED activity channel: ON window of HOLD ticks, then  |
// |               a forced GAP of GAP ticks; strobes seen while busy are   |
// |               collapsed into a single follow-on window.                |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module activity_chan
  import midi_pkg::*;
#(
  parameter int HOLD = DEF_HOLD,
  parameter int GAP  = DEF_GAP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  input  logic tick,
  output logic act
);

  localparam int            CW     = cnt_width(HOLD, GAP);
  localparam logic [CW-1:0] C_HOLD = CW'(HOLD);
  localparam logic [CW-1:0] C_GAP  = CW'(GAP);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  chan_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic          r_pend,  w_pend_nxt;
  logic          r_act;

  // Next-state logic: window sequencing, tick countdown and pending request.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    case (r_state)
      ST_IDLE: begin
        if (strobe) begin
          w_state_nxt = ST_ON;
          w_cnt_nxt   = C_HOLD;
        end
      end
      ST_ON: begin
        w_pend_nxt = r_pend | strobe;
        if (tick) begin
          if (r_cnt == C_ONE) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = C_GAP;
          end else begin
            w_cnt_nxt   = r_cnt - C_ONE;
          end
        end
      end
      ST_GAP: begin
        // A strobe on the final gap tick still counts as a request.
        w_pend_nxt = r_pend | strobe;
        if (tick) begin
          if (r_cnt == C_ONE) begin
            if (w_pend_nxt) begin
              w_state_nxt = ST_ON;
              w_cnt_nxt   = C_HOLD;
              w_pend_nxt  = 1'b0;
            end else begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt   = r_cnt - C_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  // State registers; the LED bit gets its own flop so the output is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_act   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_act   <= (w_state_nxt == ST_ON);
    end
  end

  assign act = r_act;

endmodule
`default_nettype wire

// File: rtl/midi_activity_stretch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : midi_activity_stretch                                    |
// | Description : Stretches per-port MIDI byte strobes into visible LED    |
// |               activity bits for the in/out LED scanner buses.          |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module midi_activity_stretch
  import midi_pkg::*;
#(
  parameter int NCH      = midi_pkg::NCH,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int HOLD     = DEF_HOLD,
  parameter int GAP      = DEF_GAP
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] in_strobe,
  input  logic [NCH-1:0] out_strobe,
  output logic [NCH-1:0] in_act,
  output logic [NCH-1:0] out_act
);

  if (HOLD < 1 || GAP < 1 || TICK_DIV < 2) begin : g_param_check
    $error("midi_activity_stretch: HOLD and GAP must be >= 1, TICK_DIV >= 2");
  end

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] C_PCNT_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]    r_pcnt;
  logic             w_tick;
  logic [2*NCH-1:0] w_strobe_all;
  logic [2*NCH-1:0] w_act_all;

  assign w_tick = (r_pcnt == C_PCNT_MAX);

  // Free-running prescaler shared by every channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  // Input ports occupy the low half, output ports the high half.
  assign w_strobe_all = {out_strobe, in_strobe};

  for (genvar g = 0; g < 2*NCH; g++) begin : g_chan
    activity_chan #(
      .HOLD (HOLD),
      .GAP  (GAP)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .strobe (w_strobe_all[g]),
      .tick   (w_tick),
      .act    (w_act_all[g])
    );
  end

  assign in_act  = w_act_all[NCH-1:0];
  assign out_act = w_act_all[2*NCH-1:NCH];

endmodule
`default_nettype wire
